// File: rtl/pbkdf2_host_if_if.sv
// pbkdf2_host_if_if: host word stream, pbkdf2 request/result and result-word handshakes
interface pbkdf2_host_if_if;
  logic         word_v_i;
  logic [31:0]  word_i;
  logic         word_ready_o;
  logic         req_v_o;
  logic         req_ready_i;
  logic [5:0]   req_slen_o;
  logic [31:0]  req_iters_o;
  logic [511:0] req_pass_o;
  logic [511:0] req_salt_o;
  logic         hash_v_i;
  logic [255:0] hash_i;
  logic         hash_ready_o;
  logic         res_v_o;
  logic [31:0]  res_word_o;
  logic         res_ready_i;
  logic         busy_o;
  modport slave (
    input  word_v_i, word_i, req_ready_i, hash_v_i, hash_i, res_ready_i,
    output word_ready_o, req_v_o, req_slen_o, req_iters_o, req_pass_o, req_salt_o,
           hash_ready_o, res_v_o, res_word_o, busy_o
  );
  modport master (
    output word_v_i, word_i, req_ready_i, hash_v_i, hash_i, res_ready_i,
    input  word_ready_o, req_v_o, req_slen_o, req_iters_o, req_pass_o, req_salt_o,
           hash_ready_o, res_v_o, res_word_o, busy_o
  );
endinterface

// File: rtl/pbkdf2_host_if.sv
// pbkdf2_host_if: packs 34 host words into one pbkdf2 request and returns the 256-bit result as 8 words
module pbkdf2_host_if (
  input logic             clk_i,
  input logic             rst_ni,
  pbkdf2_host_if_if.slave bus
);
  typedef enum logic [1:0] {LOAD, ISSUE, WAIT, DRAIN} state_t;
  state_t       r_state, w_next;
  logic [5:0]   r_cnt;
  logic [5:0]   r_slen;
  logic [31:0]  r_iters;
  logic [511:0] r_pass, r_salt;
  logic [255:0] r_hash;
  logic         w_word_acc, w_req_acc, w_hash_acc, w_res_acc;
  assign w_word_acc = bus.word_v_i & (r_state == LOAD);
  assign w_req_acc  = bus.req_ready_i & (r_state == ISSUE);
  assign w_hash_acc = bus.hash_v_i & (r_state == WAIT);
  assign w_res_acc  = bus.res_ready_i & (r_state == DRAIN);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_state <= LOAD;
    else r_state <= w_next;
  always_comb
    w_next = (w_word_acc && r_cnt == 6'd33) ? ISSUE :
             w_req_acc                      ? WAIT  :
             w_hash_acc                     ? DRAIN :
             (w_res_acc && r_cnt == 6'd7)   ? LOAD  : r_state;
  always_comb begin
    bus.word_ready_o = r_state == LOAD;
    bus.req_v_o      = r_state == ISSUE;
    bus.hash_ready_o = r_state == WAIT;
    bus.res_v_o      = r_state == DRAIN;
    bus.res_word_o   = (r_state == DRAIN) ? r_hash[255:224] : 32'd0;
    bus.busy_o       = r_state != LOAD;
    bus.req_slen_o   = r_slen;
    bus.req_iters_o  = r_iters;
    bus.req_pass_o   = r_pass;
    bus.req_salt_o   = r_salt;
  end
  // pass/salt and the result shift MS word first, so word order falls out of the shift direction
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_cnt   <= 6'd0;
      r_slen  <= 6'd0;
      r_iters <= 32'd0;
      r_pass  <= '0;
      r_salt  <= '0;
      r_hash  <= '0;
    end else begin
      if (w_hash_acc) r_cnt <= 6'd0;
      else if (w_word_acc || w_res_acc) r_cnt <= (w_next != r_state) ? 6'd0 : r_cnt + 6'd1;
      if (w_word_acc && r_cnt == 6'd0) r_slen <= bus.word_i[5:0];
      if (w_word_acc && r_cnt == 6'd1) r_iters <= bus.word_i;
      if (w_word_acc && r_cnt >= 6'd2 && r_cnt <= 6'd17) r_pass <= {r_pass[479:0], bus.word_i};
      if (w_word_acc && r_cnt >= 6'd18) r_salt <= {r_salt[479:0], bus.word_i};
      if (w_hash_acc) r_hash <= bus.hash_i;
      else if (w_res_acc) r_hash <= {r_hash[223:0], 32'd0};
    end
endmodule

// File: tb/tb_pbkdf2_host_if.sv
// tb_pbkdf2_host_if: directed requests against a queue-based model of the host interface
module tb_pbkdf2_host_if;
  typedef logic [31:0] req_t [34];
  typedef logic [31:0] res_t [8];
  logic clk_i = 0;
  logic rst_ni = 0;
  int total = 0;
  int bad = 0;
  bit run = 0;
  pbkdf2_host_if_if bus();
  pbkdf2_host_if dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));
  always #5 clk_i = ~clk_i;

  localparam logic [255:0] G1 = 256'h120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b;
  localparam logic [255:0] G2 = 256'hae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [31:0]  m_w[$];
  logic [31:0]  m_res[$];
  bit           m_issue, m_wait;
  logic [5:0]   m_slen;
  logic [31:0]  m_iters;
  logic [511:0] m_pass, m_salt;
  always @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      m_w.delete(); m_res.delete();
      m_issue = 0; m_wait = 0;
      m_slen = '0; m_iters = '0; m_pass = '0; m_salt = '0;
    end else if (!m_issue && !m_wait && m_res.size() == 0) begin
      if (bus.word_v_i) begin
        m_w.push_back(bus.word_i);
        if (m_w.size() == 34) begin
          m_slen = m_w[0][5:0];
          m_iters = m_w[1];
          for (int k = 0; k < 16; k++) begin
            m_pass[511-32*k -: 32] = m_w[2+k];
            m_salt[511-32*k -: 32] = m_w[18+k];
          end
          m_w.delete();
          m_issue = 1;
        end
      end
    end else if (m_issue) begin
      if (bus.req_ready_i) begin m_issue = 0; m_wait = 1; end
    end else if (m_wait) begin
      if (bus.hash_v_i) begin
        m_wait = 0;
        for (int k = 0; k < 8; k++) m_res.push_back(bus.hash_i[255-32*k -: 32]);
      end
    end else if (bus.res_ready_i) void'(m_res.pop_front());

  always @(negedge clk_i)
    if (run) begin
      automatic bit idle = !m_issue && !m_wait && m_res.size() == 0;
      chk("word_ready", bus.word_ready_o, idle);
      chk("busy", bus.busy_o, !idle);
      chk("req_v", bus.req_v_o, m_issue);
      chk("hash_ready", bus.hash_ready_o, m_wait);
      chk("res_v", bus.res_v_o, m_res.size() != 0);
      if (m_res.size() != 0) chk("res_word", bus.res_word_o, m_res[0]);
      if (m_issue) begin
        chk("slen", bus.req_slen_o, m_slen);
        chk("iters", bus.req_iters_o, m_iters);
        chk("pass", bus.req_pass_o, m_pass);
        chk("salt", bus.req_salt_o, m_salt);
      end
    end

  function automatic req_t mk_req(input logic [31:0] w0, input logic [31:0] it,
                                  input logic [511:0] p, input logic [511:0] s);
    req_t r;
    r[0] = w0;
    r[1] = it;
    for (int k = 0; k < 16; k++) begin
      r[2+k]  = p[511-32*k -: 32];
      r[18+k] = s[511-32*k -: 32];
    end
    return r;
  endfunction

  task automatic send_req(input req_t w);
    for (int i = 0; i < 34; i++) begin
      int n = 0;
      bus.word_v_i = 1;
      bus.word_i = w[i];
      while (!bus.word_ready_o && n < 200) begin @(posedge clk_i); #1; n++; end
      if (n >= 200) chk("word_accept_timeout", 1, 0);
      @(posedge clk_i); #1;
    end
    bus.word_v_i = 0;
    bus.word_i = '0;
  endtask

  task automatic run_req(input req_t w, input logic [255:0] h, input bit stall, input bit toggle,
                         output res_t got);
    int n = 0;
    int c = 0;
    send_req(w);
    chk("req_v_after_last_word", bus.req_v_o, 1);
    chk("no_word_ready_in_issue", bus.word_ready_o, 0);
    if (stall) begin
      bus.hash_v_i = 1;
      bus.hash_i = ~h;
      repeat (10) @(posedge clk_i);
      #1;
      bus.hash_v_i = 0;
      chk("issue_hold_req_v", bus.req_v_o, 1);
      chk("issue_hold_word_ready", bus.word_ready_o, 0);
    end
    bus.req_ready_i = 1;
    @(posedge clk_i); #1;
    bus.req_ready_i = 0;
    chk("hash_ready_in_wait", bus.hash_ready_o, 1);
    repeat (3) @(posedge clk_i);
    #1;
    bus.hash_v_i = 1;
    bus.hash_i = h;
    @(posedge clk_i); #1;
    bus.hash_v_i = 0;
    bus.hash_i = '0;
    while (n < 8 && c < 100) begin
      bus.res_ready_i = toggle ? c[0] : 1'b1;
      if (bus.res_v_o && bus.res_ready_i) begin got[n] = bus.res_word_o; n++; end
      @(posedge clk_i); #1;
      c++;
    end
    if (n < 8) chk("drain_timeout", n, 8);
    bus.res_ready_i = 0;
    chk("idle_after_drain", bus.busy_o, 0);
  endtask

  initial begin
    req_t r;
    res_t got;
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    req_t r;
    res_t got;
    bus.word_v_i = 0; bus.word_i = '0; bus.req_ready_i = 0;
    bus.hash_v_i = 0; bus.hash_i = '0; bus.res_ready_i = 0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_req_v", bus.req_v_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_res_v", bus.res_v_o, 0);
    chk("rst_res_word", bus.res_word_o, 0);
    chk("rst_hash_ready", bus.hash_ready_o, 0);
    run = 1;
    @(negedge clk_i);
    rst_ni = 1;
    @(posedge clk_i); #1;
    chk("post_rst_word_ready", bus.word_ready_o, 1);

    // test 1: partial request of 5 words, then reset; the following 34 words must stand alone
    for (int i = 0; i < 5; i++) begin
      bus.word_v_i = 1; bus.word_i = 32'hdead0000 + i;
      @(posedge clk_i); #1;
    end
    bus.word_v_i = 0;
    rst_ni = 0;
    #2;
    chk("midrst_word_ready", bus.word_ready_o, 1);
    chk("midrst_req_v", bus.req_v_o, 0);
    @(negedge clk_i);
    rst_ni = 1;
    @(posedge clk_i); #1;

    // tests 2-4: fields land MS word first, ISSUE stall, staged result drained with host backpressure
    r = mk_req(32'h5, 32'h2, 512'h70617373 << 480, 512'h73616c74 << 480);
    send_req(r);
    chk("t2_slen", bus.req_slen_o, 6'd5);
    chk("t2_iters", bus.req_iters_o, 32'd2);
    chk("t2_pass_top", bus.req_pass_o[511:480], 32'h70617373);
    chk("t2_salt_top", bus.req_salt_o[511:480], 32'h73616c74);
    chk("t2_pass_rest", bus.req_pass_o[479:0], 0);
    bus.req_ready_i = 0;
    repeat (10) @(posedge clk_i);
    #1;
    chk("t3_req_v_held", bus.req_v_o, 1);
    chk("t3_iters_held", bus.req_iters_o, 32'd2);
    chk("t3_word_ready", bus.word_ready_o, 0);
    bus.req_ready_i = 1;
    @(posedge clk_i); #1;
    bus.req_ready_i = 0;
    bus.hash_v_i = 1;
    bus.hash_i = 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008;
    @(posedge clk_i); #1;
    bus.hash_v_i = 0;
    for (int k = 0; k < 8; k++) begin
      bus.res_ready_i = 0;
      @(posedge clk_i); #1;
      chk("t4_hold", bus.res_word_o, k + 1);
      bus.res_ready_i = 1;
      @(posedge clk_i); #1;
    end
    bus.res_ready_i = 0;
    chk("t4_back_to_load", bus.word_ready_o, 1);

    // test 5: upper bits of word 0 are dropped
    r = mk_req(32'hFFFFFFC3, 32'h1, '1, '0);
    run_req(r, 256'h0123, 1, 1, got);
    chk("t5_slen_model", m_slen, 6'h03);
    chk("t5_last_word", got[7], 32'h0123);

    // test 6: two back-to-back RFC requests, "password"/"salt" with iters 1 and 2
    for (int t = 1; t <= 2; t++) begin
      r = mk_req(32'd4, t, 512'h70617373_776f7264 << 448, 512'h73616c74 << 480);
      run_req(r, (t == 1) ? G1 : G2, 0, t == 2, got);
      for (int k = 0; k < 8; k++) chk($sformatf("t6_iters%0d_w%0d", t, k), got[k],
                                      ((t == 1) ? G1 : G2) >> (224 - 32*k) & 256'hffffffff);
    end
    chk("t6_lit_w0", got[0], 32'hae4d0c95);
    run = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
